// File: rtl/imem_dmem_arbiter_pkg.sv
// rtl/imem_dmem_arbiter_pkg.sv - shared types for the unified imem/dmem arbiter
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    // Wide enough for the largest allowed data-run limit (15).
    localparam int RUN_W = 4;

endpackage

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - fetch/data arbiter for one single-ported unified memory
module imem_dmem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_D_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

    state_t              state_q, state_d;
    gnt_t                gnt;
    logic                arb_open;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_valid_q, if_valid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_valid_q, d_valid_d;
    logic [RUN_W-1:0]    run_q, run_d;

    // The completion cycle is a dead arbitration slot: requesters are still
    // presenting the request that just finished, so nothing is sampled then.
    always_comb begin
        arb_open = (state_q == IDLE) && !if_valid_q && !d_valid_q;
        gnt      = GNT_NONE;
        if (arb_open) begin
            if (if_req && (!d_req || run_q == RUN_MAX)) begin
                gnt = GNT_I;
            end else if (d_req) begin
                gnt = GNT_D;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                case (gnt)
                    GNT_I: begin
                        state_d     = BUSY_I;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                    GNT_D: begin
                        state_d     = BUSY_D;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wstrb_d = d_wstrb;
                    end
                    default: ;
                endcase
            end
            BUSY_I: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Counts data grants that overtook a waiting fetch.
    always_comb begin
        run_d = run_q;
        if (!if_req || gnt == GNT_I) begin
            run_d = '0;
        end else if (gnt == GNT_D && run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_valid_q   <= 1'b0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if_rdata_q  <= if_rdata_d;
            if_valid_q  <= if_valid_d;
            d_rdata_q   <= d_rdata_d;
            d_valid_q   <= d_valid_d;
            run_q       <= run_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_valid   = d_valid_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign d_stall   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed vector bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [31:0] P = 32'h0050_0293;
    localparam logic [3:0]  S0 = 4'h0;
    localparam logic [3:0]  SF = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_valid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [3:0]  d_wstrb;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req, e_mem_we;
        logic [31:0] e_mem_addr, e_mem_wdata;
        logic [3:0]  e_mem_wstrb;
        logic        e_if_valid;
        logic [31:0] e_if_rdata;
        logic        e_d_valid;
        logic [31:0] e_d_rdata;
        logic        e_if_stall, e_d_stall;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_wstrb = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    initial begin
        int ngr;
        int last;
        logic prev_req;
        logic exp_i;

        rst = 1;
        idle_inputs();
        tick();
        tick();

        //          rst ifr ifa       dr dwe da        dwd           dws ack mrd             | mreq mwe maddr     mwd           mws ifv ifrd dv drd           ifs ds
        vq.push_back('{H, L, Z,        L, L, Z,        Z,            S0, L, Z,              L, L, Z,        Z,            S0, L, Z, L, Z,            L, L});
        // fetch, one wait cycle
        vq.push_back('{L, H, 32'h10,   L, L, Z,        Z,            S0, L, Z,              L, L, Z,        Z,            S0, L, Z, L, Z,            H, L});
        vq.push_back('{L, H, 32'h10,   L, L, Z,        Z,            S0, L, Z,              H, L, 32'h10,   Z,            S0, L, Z, L, Z,            H, L});
        vq.push_back('{L, H, 32'h10,   L, L, Z,        Z,            S0, H, P,              H, L, 32'h10,   Z,            S0, L, Z, L, Z,            H, L});
        vq.push_back('{L, H, 32'h10,   L, L, Z,        Z,            S0, L, Z,              L, L, 32'h10,   Z,            S0, H, P, L, Z,            L, L});
        vq.push_back('{L, L, Z,        L, L, Z,        Z,            S0, L, Z,              L, L, 32'h10,   Z,            S0, L, P, L, Z,            L, L});
        // write, read data on the bus must not be captured
        vq.push_back('{L, L, Z,        H, H, 32'h40,   32'hDEADBEEF, SF, L, Z,              L, L, 32'h10,   Z,            S0, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, H, 32'h40,   32'hDEADBEEF, SF, H, 32'hAAAAAAAA,   H, H, 32'h40,   32'hDEADBEEF, SF, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, H, 32'h40,   32'hDEADBEEF, SF, L, Z,              L, H, 32'h40,   32'hDEADBEEF, SF, L, P, H, Z,            L, L});
        vq.push_back('{L, L, Z,        L, L, Z,        Z,            S0, L, Z,              L, H, 32'h40,   32'hDEADBEEF, SF, L, P, L, Z,            L, L});
        // read with three wait states
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, L, Z,              L, H, 32'h40,   32'hDEADBEEF, SF, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, L, Z,              H, L, 32'h80,   Z,            S0, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, L, Z,              H, L, 32'h80,   Z,            S0, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, L, Z,              H, L, 32'h80,   Z,            S0, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, H, 32'h12345678,   H, L, 32'h80,   Z,            S0, L, P, L, Z,            L, H});
        vq.push_back('{L, L, Z,        H, L, 32'h80,   Z,            S0, L, Z,              L, L, 32'h80,   Z,            S0, L, P, H, 32'h12345678, L, L});
        vq.push_back('{L, L, Z,        L, L, Z,        Z,            S0, L, Z,              L, L, 32'h80,   Z,            S0, L, P, L, 32'h12345678, L, L});
        // stray ack in idle
        vq.push_back('{L, L, Z,        L, L, Z,        Z,            S0, H, 32'hFFFFFFFF,   L, L, 32'h80,   Z,            S0, L, P, L, 32'h12345678, L, L});
        vq.push_back('{L, L, Z,        L, L, Z,        Z,            S0, L, Z,              L, L, 32'h80,   Z,            S0, L, P, L, 32'h12345678, L, L});

        foreach (vq[i]) begin
            rst = vq[i].rst; if_req = vq[i].if_req; if_addr = vq[i].if_addr;
            d_req = vq[i].d_req; d_we = vq[i].d_we; d_addr = vq[i].d_addr;
            d_wdata = vq[i].d_wdata; d_wstrb = vq[i].d_wstrb;
            mem_ack = vq[i].mem_ack; mem_rdata = vq[i].mem_rdata;
            #2;
            chk($sformatf("v%0d mem_req", i),   {31'b0, mem_req},  {31'b0, vq[i].e_mem_req});
            chk($sformatf("v%0d mem_we", i),    {31'b0, mem_we},   {31'b0, vq[i].e_mem_we});
            chk($sformatf("v%0d mem_addr", i),  mem_addr,          vq[i].e_mem_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,         vq[i].e_mem_wdata);
            chk($sformatf("v%0d mem_wstrb", i), {28'b0, mem_wstrb}, {28'b0, vq[i].e_mem_wstrb});
            chk($sformatf("v%0d if_valid", i),  {31'b0, if_valid}, {31'b0, vq[i].e_if_valid});
            chk($sformatf("v%0d if_rdata", i),  if_rdata,          vq[i].e_if_rdata);
            chk($sformatf("v%0d d_valid", i),   {31'b0, d_valid},  {31'b0, vq[i].e_d_valid});
            chk($sformatf("v%0d d_rdata", i),   d_rdata,           vq[i].e_d_rdata);
            chk($sformatf("v%0d if_stall", i),  {31'b0, if_stall}, {31'b0, vq[i].e_if_stall});
            chk($sformatf("v%0d d_stall", i),   {31'b0, d_stall},  {31'b0, vq[i].e_d_stall});
            tick();
        end

        // Continuous contention, zero-wait memory: expect D,D,D,D,I repeating, 3 cycles apart.
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        if_req = 1; if_addr = 32'h100;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        ngr = 0;
        last = 0;
        prev_req = 0;
        for (int cyc = 0; cyc < 80 && ngr < 10; cyc++) begin
            mem_ack = mem_req;
            mem_rdata = 32'h1000 + 32'(cyc);
            #2;
            if (mem_req && !prev_req) begin
                exp_i = (ngr % 5 == 4);
                chk($sformatf("grant%0d is_fetch", ngr), {31'b0, mem_addr == 32'h100}, {31'b0, exp_i});
                if (ngr > 0) chk($sformatf("grant%0d spacing", ngr), 32'(cyc - last), 32'd3);
                last = cyc;
                ngr++;
            end
            prev_req = mem_req;
            tick();
        end
        chk("grant count", 32'(ngr), 32'd10);

        // Reset while a data read is outstanding.
        rst = 1;
        idle_inputs();
        tick();
        rst = 0;
        d_req = 1; d_we = 0; d_addr = 32'h300;
        #2;
        chk("rst d_stall before grant", {31'b0, d_stall}, 32'd1);
        tick();
        #2;
        chk("rst busy mem_req", {31'b0, mem_req}, 32'd1);
        chk("rst busy mem_addr", mem_addr, 32'h300);
        rst = 1; d_req = 0;
        tick();
        rst = 0;
        #2;
        chk("rst mem_req dropped", {31'b0, mem_req}, 32'd0);
        chk("rst no d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst mem_addr cleared", mem_addr, 32'h0);
        mem_ack = 1; mem_rdata = 32'h55555555;
        tick();
        mem_ack = 0;
        #2;
        chk("rst late ack no d_valid", {31'b0, d_valid}, 32'd0);
        chk("rst late ack d_rdata", d_rdata, 32'h0);
        d_req = 1; d_addr = 32'h304;
        tick();
        #2;
        chk("post-rst mem_req", {31'b0, mem_req}, 32'd1);
        chk("post-rst mem_addr", mem_addr, 32'h304);
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 0;
        #2;
        chk("post-rst d_valid", {31'b0, d_valid}, 32'd1);
        chk("post-rst d_rdata", d_rdata, 32'hCAFEF00D);
        chk("post-rst mem_req low", {31'b0, mem_req}, 32'd0);
        d_req = 0;
        tick();
        #2;
        chk("post-rst d_valid single", {31'b0, d_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
